// File: rtl/fft_feeder_pkg.sv
// fft_feeder_pkg: bank and read-FSM states, tdata field positions and the triangular window weight.
package fft_feeder_pkg;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
   typedef enum logic [1:0] {IDLE, FETCH, STREAM} read_state_t;
   localparam int REAL_LSB = 0;
   localparam int IMAG_LSB = 16;
   // (min(i, N-1-i) * 1024) / N with N = 2**lg; the upper half mirrors by bit inversion
   function automatic logic [8:0] tri_weight(input logic [11:0] idx, input int lg);
      logic [11:0] m;
      logic [21:0] s;
      m = (idx[lg-1] ? ~idx : idx) & 12'((1 << lg) - 1);
      s = (lg <= 10) ? ({10'd0, m} << (10 - lg)) : ({10'd0, m} >> (lg - 10));
      return s[8:0];
   endfunction
endpackage

// File: rtl/frame_bank_ram.sv
// frame_bank_ram: DEPTH x 8 sample bank, one write port and one registered read port.
module frame_bank_ram #(
   parameter int DEPTH = 1024,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk_in,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);
   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;
   always_ff @(posedge clk_in) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end
   assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: ping-pong frame buffer streaming 8-bit audio frames to an AXI-Stream FFT.
// Define FFT_FEEDER_WINDOW_EN for a triangular window (adds one pipeline stage).
module fft_frame_feeder
   import fft_feeder_pkg::*;
#(
   parameter int FRAME_LEN = 1024
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        audio_valid_in,
   input  logic [7:0]  audio_in,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        drop_out,
   output logic [15:0] frames_out
);
   localparam int AW = $clog2(FRAME_LEN);
   localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);
   read_state_t r_rd_state, w_rd_next;
   bank_state_t r_bank [2];
   logic r_rd_bank, r_wr_bank, r_own, r_drop;
   logic [AW:0] r_rd_addr;
   logic [AW-1:0] r_beat, r_wr_idx;
   logic [15:0] r_frames;
   logic w_fire, w_adv, w_re, w_rel, w_ok, w_we, w_fetch_done;
   logic [1:0] w_empty;
   logic [7:0] w_q0, w_q1, w_q;
   logic [15:0] w_real;

   frame_bank_ram #(.DEPTH(FRAME_LEN)) u_bank0 (
      .clk_in(clk_in), .i_we(w_we && !r_wr_bank), .i_waddr(r_wr_idx), .i_wdata(audio_in),
      .i_re(w_re && !r_rd_bank), .i_raddr(r_rd_addr[AW-1:0]), .o_rdata(w_q0));
   frame_bank_ram #(.DEPTH(FRAME_LEN)) u_bank1 (
      .clk_in(clk_in), .i_we(w_we && r_wr_bank), .i_waddr(r_wr_idx), .i_wdata(audio_in),
      .i_re(w_re && r_rd_bank), .i_raddr(r_rd_addr[AW-1:0]), .o_rdata(w_q1));

   assign w_q = r_rd_bank ? w_q1 : w_q0;
   // r_rd_addr[AW] marks the frame fully fetched, so no read strays into a freed bank
   assign w_re = w_adv && !r_rd_addr[AW];
   // a bank freed by this cycle's last beat counts as empty for the writer
   assign w_empty[0] = r_bank[0] == EMPTY || (w_rel && !r_rd_bank);
   assign w_empty[1] = r_bank[1] == EMPTY || (w_rel && r_rd_bank);
   assign w_ok = r_own || w_empty[r_wr_bank];
   assign w_we = audio_valid_in && w_ok;

`ifdef FFT_FEEDER_WINDOW_EN
   logic [AW-1:0] r_q_idx;
   logic [15:0] r_win;
   logic signed [16:0] w_prod;
   assign w_prod = 17'($signed(w_q)) * 17'($signed({1'b0, tri_weight(12'(r_q_idx), AW)}));
   always_ff @(posedge clk_in) begin
      if (w_adv) begin
         r_q_idx <= r_rd_addr[AW-1:0];
         r_win <= 16'(w_prod >>> 1);
      end
   end
   assign w_real = r_win;
   assign w_fetch_done = r_rd_addr[0];
`else
   assign w_real = {w_q, 8'd0};
   assign w_fetch_done = 1'b1;
`endif

   always_comb begin
      w_rd_next = r_rd_state;
      w_fire = r_rd_state == STREAM && m_axis_tready;
      w_rel = w_fire && r_beat == LAST;
      w_adv = r_rd_state == FETCH || w_fire;
      if (r_rd_state == IDLE && r_bank[r_rd_bank] == FULL) w_rd_next = FETCH;
      if (r_rd_state == FETCH && w_fetch_done) w_rd_next = STREAM;
      if (w_rel) w_rd_next = IDLE;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_rd_state <= IDLE;
         r_bank[0] <= EMPTY;
         r_bank[1] <= EMPTY;
         r_rd_bank <= 1'b0;
         r_wr_bank <= 1'b0;
         r_own <= 1'b0;
         r_drop <= 1'b0;
         r_rd_addr <= '0;
         r_beat <= '0;
         r_wr_idx <= '0;
         r_frames <= '0;
      end else begin
         r_rd_state <= w_rd_next;
         r_drop <= audio_valid_in && !w_ok;
         if (r_rd_state == IDLE) r_rd_addr <= '0;
         else if (w_adv) r_rd_addr <= r_rd_addr + 1'b1;
         if (r_rd_state == IDLE) r_beat <= '0;
         else if (w_fire) r_beat <= r_beat + 1'b1;
         if (r_rd_state == IDLE && w_rd_next == FETCH) r_bank[r_rd_bank] <= DRAINING;
         if (w_rel) begin
            r_bank[r_rd_bank] <= EMPTY;
            r_rd_bank <= ~r_rd_bank;
            r_frames <= r_frames + 1'b1;
         end
         // writer claims its target bank as soon as it is empty; this overrides the release above
         if (!r_own && w_empty[r_wr_bank]) begin
            r_own <= 1'b1;
            r_bank[r_wr_bank] <= FILLING;
         end
         if (w_we) begin
            r_wr_idx <= r_wr_idx + 1'b1;
            if (r_wr_idx == LAST) begin
               r_bank[r_wr_bank] <= FULL;
               r_wr_bank <= ~r_wr_bank;
               r_own <= w_empty[~r_wr_bank];
               if (w_empty[~r_wr_bank]) r_bank[~r_wr_bank] <= FILLING;
            end
         end
      end
   end

   assign m_axis_tvalid = r_rd_state == STREAM;
   assign m_axis_tlast = m_axis_tvalid && r_beat == LAST;
   assign m_axis_tdata = m_axis_tvalid ? ((32'(w_real) << REAL_LSB) | (32'(16'h0000) << IMAG_LSB)) : '0;
   assign drop_out = r_drop;
   assign frames_out = r_frames;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb_fft_frame_feeder: directed checks of framing, backpressure, overflow, simultaneous free and reset.
module tb_fft_frame_feeder;
   localparam int N = 16;
`ifdef FFT_FEEDER_WINDOW_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif
   logic clk = 1'b0, rst = 1'b1, vld = 1'b0, rdy = 1'b0;
   logic [7:0] aud = 8'd0;
   logic [31:0] td;
   logic tv, tl, drp;
   logic [15:0] frm;
   int n_chk = 0, n_fail = 0, n_drop = 0;
   logic [32:0] beats [$];
   logic [32:0] e7;

   fft_frame_feeder #(.FRAME_LEN(N)) dut (
      .clk_in(clk), .rst_in(rst), .audio_valid_in(vld), .audio_in(aud),
      .m_axis_tdata(td), .m_axis_tvalid(tv), .m_axis_tready(rdy), .m_axis_tlast(tl),
      .drop_out(drp), .frames_out(frm));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (tv && rdy) beats.push_back({tl, td});
         if (drp) n_drop++;
      end
   end

   function automatic logic [32:0] exp_beat(input int s, input int i);
      int r;
`ifdef FFT_FEEDER_WINDOW_EN
      int m;
      m = (i < N - 1 - i) ? i : N - 1 - i;
      r = (s * (m * 1024 / N)) >>> 1;
`else
      r = s * 256;
`endif
      return {i == N - 1, 16'h0000, r[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int s, input bit gap);
      vld = 1'b1;
      aud = 8'(s);
      cyc();
      vld = 1'b0;
      if (gap) cyc();
   endtask

   task automatic wait_beats(input int n);
      int k = 0;
      while (beats.size() < n && k < 300) begin
         cyc();
         k++;
      end
      chk("beat_count", 33'(beats.size()), 33'(n));
   endtask

   task automatic latency();
      int lat = 1;
      while (!tv && lat < 20) begin
         cyc();
         lat++;
      end
      chk("latency", 33'(lat), 33'(LAT));
   endtask

   task automatic chk_run(input string tag, input int off, input int s0, input int i0, input int n);
      for (int j = 0; j < n; j++) chk(tag, beats[off + j], exp_beat(s0 + j, i0 + j));
   endtask

   task automatic chk_reset();
      chk("rst_tdata", 33'(td), 33'd0);
      chk("rst_flags", 33'({tv, tl, drp}), 33'd0);
      chk("rst_frames", 33'(frm), 33'd0);
   endtask

   task automatic feed_frame(input int s0);
      for (int i = 0; i < N - 1; i++) feed(s0 + i, 1'b1);
      feed(s0 + N - 1, 1'b0);
   endtask

   initial begin
      int k;
      e7 = exp_beat(7, 7);
      repeat (3) cyc();
      chk_reset();
      rst = 1'b0;
      rdy = 1'b1;
      feed_frame(0);
      latency();
      wait_beats(N);
      chk_run("ramp", 0, 0, 0, N);
      chk("ramp_frames", 33'(frm), 33'd1);

      beats.delete();
      n_drop = 0;
      feed_frame(0);
      k = 0;
      while (!(tv && {tl, td} == e7) && k < 50) begin
         cyc();
         k++;
      end
      rdy = 1'b0;
      repeat (5) begin
         cyc();
         chk("bp_valid", 33'(tv), 33'd1);
         chk("bp_data", {tl, td}, e7);
      end
      rdy = 1'b1;
      wait_beats(N);
      chk_run("bp_seq", 0, 0, 0, N);
      chk("bp_drop", 33'(n_drop), 33'd0);
      chk("bp_frames", 33'(frm), 33'd2);

      rst = 1'b1;
      cyc();
      rst = 1'b0;
      beats.delete();
      n_drop = 0;
      rdy = 1'b0;
      for (int i = 0; i < 40; i++) feed(i, 1'b1);
      cyc();
      chk("ovf_drops", 33'(n_drop), 33'd8);
      chk("ovf_frames", 33'(frm), 33'd0);
      chk("ovf_valid", 33'(tv), 33'd1);
      chk("ovf_head", {tl, td}, exp_beat(0, 0));

      rdy = 1'b1;
      k = 0;
      while (!(tv && tl) && k < 50) begin
         cyc();
         k++;
      end
      feed(-5, 1'b1);
      for (int i = 1; i < N; i++) feed(i, 1'b1);
      wait_beats(3 * N);
      chk_run("sim_a", 0, 0, 0, N);
      chk_run("sim_b", N, N, 0, N);
      chk("sim_c0", beats[2 * N], exp_beat(-5, 0));
      chk_run("sim_c", 2 * N + 1, 1, 1, N - 1);
      chk("sim_drop", 33'(n_drop), 33'd8);
      chk("sim_frames", 33'(frm), 33'd3);

      beats.delete();
      feed_frame(0);
      wait_beats(4);
      rst = 1'b1;
      cyc();
      chk_reset();
      rst = 1'b0;
      beats.delete();
      feed_frame(50);
      latency();
      wait_beats(N);
      chk_run("post_rst", 0, 50, 0, N);
      chk("post_rst_frames", 33'(frm), 33'd1);

`ifdef FFT_FEEDER_WINDOW_EN
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      beats.delete();
      for (int i = 0; i < N; i++) feed(127, 1'b1);
      wait_beats(N);
      chk("win_b0", beats[0], {1'b0, 32'd0});
      chk("win_b7", beats[7], {1'b0, 16'd0, 16'd28448});
      chk("win_b15", beats[15], {1'b1, 32'd0});
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Collects the 12 kHz signed 8-bit microphone samples into fixed-length frames and streams each complete frame into the FFT core's AXI-Stream slave port, asserting tlast on the last sample. It sits between the PDM decimator (audio_sample_valid / mic_audio) and the FFT. It replaces ad-hoc tvalid/tlast generation with a ping-pong frame buffer and a proper handshake.

## Interface
- FRAME_LEN, 1024: samples per frame; power of two, 16..4096; must equal the FFT transform length.
- clk_in  input  1  system clock (clk_m domain).
- rst_in  input  1  synchronous, active-high reset.
- audio_valid_in  input  1  single-cycle sample strobe (~12 kHz).
- audio_in  input  8  signed sample.
- m_axis_tdata  output  32  [15:0] real, [31:16] imaginary (always 0).
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  FFT ready.
- m_axis_tlast  output  1  high on sample FRAME_LEN-1 of a frame.
- drop_out  output  1  one-cycle pulse per discarded input sample.
- frames_out  output  16  count of frames fully handed off; wraps at 65535 -> 0.

## Operation
- Two banks of FRAME_LEN x 8 bits, with 1-cycle registered read. Each bank is EMPTY, FILLING, FULL or DRAINING.
- Write side: samples are written to the current write bank at index wr_idx, which increments.
- At wr_idx == FRAME_LEN-1 the bank becomes FULL and wr_idx wraps to 0.
  - If the other bank is EMPTY, it becomes FILLING.
  - Otherwise the write side enters WAIT.
- In WAIT every audio_valid_in is dropped and pulses drop_out. A frame always starts at index 0 of a bank; partial frames never exist.
- Read side FSM: IDLE -> FETCH (issue read of index 0) -> STREAM -> IDLE.
  - The FULL bank becomes DRAINING on entering FETCH.
  - In STREAM a beat completes on tvalid && tready; rd_idx advances and the next read is issued.
  - On the handshake of the last beat, the bank becomes EMPTY, frames_out increments, and the FSM returns to IDLE. It goes to FETCH in the following cycle if the other bank is FULL.
- Banks drain in fill order.
- Without the window, real = {audio_in, 8'b0}.
- AXI rules:
  - tdata and tlast are held stable while tvalid && !tready.
  - tvalid never drops without a handshake.
  - Sustained throughput is 1 beat/cycle while tready is high.
- Simultaneous events:
  - Last-beat handshake on the same cycle as audio_valid_in while in WAIT: the sample is written at index 0 of the freed bank and is not dropped.
  - A read and a write of the same bank on the same cycle cannot occur.

## Timing
- Reset: tvalid=0, tlast=0, tdata=0, drop_out=0, frames_out=0, both banks EMPTY, write bank 0, wr_idx=0, read FSM IDLE. Reset mid-frame discards all buffered data.
- Latency is measured from the audio_valid_in cycle completing a bank to the first tvalid:
  - 3 cycles without WINDOW_EN;
  - 4 cycles with it.
- Per beat, tready to next tdata is 0 cycles (no bubbles).
- drop_out is asserted in the cycle after the dropped strobe.

## Configuration
- Macro FFT_FEEDER_WINDOW_EN enables a triangular window.
  - Weight w(i) = (min(i, FRAME_LEN-1-i) * 1024) / FRAME_LEN, giving 0..511, computed with shifts only.
  - real = (audio_in * w) >>> 1, signed 17-bit product truncated to 16 bits. No overflow is possible.
  - The window adds one pipeline register stage.
- Without the macro: rectangular window, real = {audio_in, 8'b0}, and no extra stage.

## Structure
- A shared package fft_feeder_pkg holds:
  - bank_state_t {EMPTY, FILLING, FULL, DRAINING};
  - read_state_t {IDLE, FETCH, STREAM};
  - the tdata packing constants REAL_LSB=0 and IMAG_LSB=16.
- Sub-module frame_bank_ram: a single-port-write, single-port-read FRAME_LEN x 8 RAM with registered read, instantiated twice.

## Test plan
- Ramp test, FRAME_LEN=16: feed audio_in=0..15 with tready=1.
  - 16 beats, real = {i, 8'h00}, tlast only on beat 15, frames_out=1, first tvalid 3 cycles after the 16th strobe.
- Backpressure: during streaming, hold tready=0 for 5 cycles at beat 7.
  - tdata stays {7, 8'h00} and tvalid stays high throughout; sequence resumes intact; no drop_out.
- Overflow: tready=0 throughout while 40 samples are fed.
  - Banks hold samples 0..15 and 16..31; drop_out pulses 8 times (samples 32..39); frames_out=0.
- Simultaneous free: in WAIT, release tready so the last beat handshakes on the same cycle as a strobe with audio_in=-5.
  - That sample is stored at index 0 of the freed bank and later emitted as real=16'hFB00; no drop_out.
- Reset mid-frame: rst_in for 1 cycle after beat 3.
  - All outputs return to reset values; the next 16 samples produce a clean frame starting at the first post-reset sample.
- FFT_FEEDER_WINDOW_EN: constant audio_in=127, FRAME_LEN=16.
  - Beat 0 real=0; beat 7 real = (127*448)>>>1 = 28448; beat 15 real=0; latency 4 cycles.
